// File: rtl/mips_cache_pkg.sv
// Shared types and defaults for the direct-mapped data cache.
// Contents:
//   XLEN_DEFAULT / INDEX_BITS_DEFAULT - default address width and index width
//   TAG_BITS / LINES                  - derived tag width and line count
//   byte_word_t                       - one 32-bit word as four bytes, index 0..3
//   cache_state_e                     - controller states
package mips_cache_pkg;

  localparam int XLEN_DEFAULT       = 32;
  localparam int INDEX_BITS_DEFAULT = 3;
  localparam int TAG_BITS           = XLEN_DEFAULT - INDEX_BITS_DEFAULT - 2;
  localparam int LINES              = 2 ** INDEX_BITS_DEFAULT;

  typedef logic [3:0][7:0] byte_word_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2,
    FLUSH     = 2'd3
  } cache_state_e;

endpackage

// File: rtl/cache_line_store.sv
// Line storage for the data cache: valid, dirty, tag and data per line.
// Ports:
//   clk, rst_b                   - clock; synchronous active-high reset clears valid/dirty
//   rd_index -> rd_valid/rd_dirty/rd_tag/rd_data  - combinational read port
//   wr_index, wr_byte_en, wr_data - per-byte data write
//   wr_fill, wr_tag              - install a line: tag written, valid set, dirty cleared
//   wr_set_dirty, wr_clr_dirty   - dirty bit control for the written line
module cache_line_store
  import mips_cache_pkg::*;
#(
  parameter int INDEX_BITS = INDEX_BITS_DEFAULT,
  parameter int TAG_W      = TAG_BITS
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic [INDEX_BITS-1:0] rd_index,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  output logic [TAG_W-1:0]      rd_tag,
  output byte_word_t            rd_data,
  input  logic [INDEX_BITS-1:0] wr_index,
  input  logic [3:0]            wr_byte_en,
  input  byte_word_t            wr_data,
  input  logic                  wr_fill,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic                  wr_set_dirty,
  input  logic                  wr_clr_dirty
);

  localparam int NLINES = 2 ** INDEX_BITS;

  logic [NLINES-1:0] valid;
  logic [NLINES-1:0] dirty;
  logic [TAG_W-1:0]  tags [NLINES];
  byte_word_t        data [NLINES];

  assign rd_valid = valid[rd_index];
  assign rd_dirty = dirty[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_data  = data[rd_index];

  // Reset wins over every write so an abandoned fill never lands in the array.
  // Tag and data arrays need no reset: they are only observed through valid.
  always_ff @(posedge clk) begin
    if (rst_b) begin
      valid <= '0;
      dirty <= '0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (wr_byte_en[b]) data[wr_index][b] <= wr_data[b];
      end
      if (wr_fill) begin
        tags[wr_index]  <= wr_tag;
        valid[wr_index] <= 1'b1;
        dirty[wr_index] <= 1'b0;
      end
      if (wr_set_dirty) dirty[wr_index] <= 1'b1;
      if (wr_clr_dirty) dirty[wr_index] <= 1'b0;
    end
  end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate data cache with one-word lines.
// Ports:
//   clk, rst_b                 - clock; synchronous active-high reset
//   core_addr/rd_en/wr_en/wdata - core load/store request (store wins if both)
//   core_rdata, core_stall     - load data (valid when !core_stall), stall to core
//   mem_addr/wdata/req/we      - backing memory request
//   mem_rdata, mem_ready       - backing memory fill data and completion pulse
//   flush_req, flush_done      - write back all dirty lines on request
//   fsm_state                  - controller state, for debug/observation
//
// Memory handshake: mem_req is held high with mem_addr/mem_we/mem_wdata stable
// for the whole transaction; the transaction completes at the rising edge where
// mem_ready is high. mem_ready while mem_req is low is ignored.
module data_cache
  import mips_cache_pkg::*;
#(
  parameter int XLEN       = XLEN_DEFAULT,
  parameter int INDEX_BITS = INDEX_BITS_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic [XLEN-1:0] core_addr,
  input  logic            core_rd_en,
  input  logic            core_wr_en,
  input  byte_word_t      core_wdata,
  output byte_word_t      core_rdata,
  output logic            core_stall,
  output logic [XLEN-1:0] mem_addr,
  output byte_word_t      mem_wdata,
  input  byte_word_t      mem_rdata,
  output logic            mem_req,
  output logic            mem_we,
  input  logic            mem_ready,
  input  logic            flush_req,
  output logic            flush_done,
  output cache_state_e    fsm_state
);

  localparam int TAG_W  = XLEN - INDEX_BITS - 2;
  localparam int SCAN_W = INDEX_BITS + 1;
  localparam logic [SCAN_W-1:0] SCAN_END = SCAN_W'(2 ** INDEX_BITS);

  cache_state_e state;

  logic [INDEX_BITS-1:0] req_index;
  logic [TAG_W-1:0]      req_tag;
  logic                  req;
  logic                  hit;
  logic                  flush_start;

  logic [INDEX_BITS-1:0] miss_index;
  logic [TAG_W-1:0]      miss_tag;

  // One bit wider than the index so the terminal count is distinct from index 0.
  logic [SCAN_W-1:0]     scan;
  logic [SCAN_W-1:0]     scan_next;
  logic [INDEX_BITS-1:0] scan_index;

  logic [INDEX_BITS-1:0] rd_index;
  logic                  rd_valid;
  logic                  rd_dirty;
  logic [TAG_W-1:0]      rd_tag;
  byte_word_t            rd_data;

  logic [INDEX_BITS-1:0] wr_index;
  logic [3:0]            wr_byte_en;
  byte_word_t            wr_data;
  logic                  wr_fill;
  logic [TAG_W-1:0]      wr_tag;
  logic                  wr_set_dirty;
  logic                  wr_clr_dirty;

  logic unused_byte_offset;

  assign unused_byte_offset = ^core_addr[1:0];

  assign req_index   = core_addr[INDEX_BITS+1:2];
  assign req_tag     = core_addr[XLEN-1:INDEX_BITS+2];
  assign req         = core_rd_en | core_wr_en;
  // hit is only meaningful in IDLE, where the read port is steered to req_index.
  assign hit         = rd_valid && (rd_tag == req_tag);
  assign flush_start = flush_req && !flush_done;
  assign scan_next   = scan + SCAN_W'(1);
  assign scan_index  = scan[INDEX_BITS-1:0];

  assign core_rdata = rd_data;
  assign mem_wdata  = rd_data;
  assign fsm_state  = state;

  cache_line_store #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W)
  ) u_store (
    .clk          (clk),
    .rst_b        (rst_b),
    .rd_index     (rd_index),
    .rd_valid     (rd_valid),
    .rd_dirty     (rd_dirty),
    .rd_tag       (rd_tag),
    .rd_data      (rd_data),
    .wr_index     (wr_index),
    .wr_byte_en   (wr_byte_en),
    .wr_data      (wr_data),
    .wr_fill      (wr_fill),
    .wr_tag       (wr_tag),
    .wr_set_dirty (wr_set_dirty),
    .wr_clr_dirty (wr_clr_dirty)
  );

  // Read-port steering, store control and memory request outputs.
  always_comb begin
    rd_index     = req_index;
    core_stall   = 1'b0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = {miss_tag, miss_index, 2'b00};
    wr_index     = req_index;
    wr_byte_en   = 4'h0;
    wr_data      = core_wdata;
    wr_fill      = 1'b0;
    wr_tag       = miss_tag;
    wr_set_dirty = 1'b0;
    wr_clr_dirty = 1'b0;
    case (state)
      IDLE: begin
        if (flush_start) begin
          core_stall = 1'b1;
        end else if (req) begin
          if (!hit) begin
            core_stall = 1'b1;
          end else if (core_wr_en) begin
            wr_byte_en   = 4'hF;
            wr_set_dirty = 1'b1;
          end
        end
      end
      WRITEBACK: begin
        // The victim is untouched until the fill, so its tag is read live.
        rd_index   = miss_index;
        core_stall = 1'b1;
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        mem_addr   = {rd_tag, miss_index, 2'b00};
      end
      FILL: begin
        rd_index   = miss_index;
        core_stall = 1'b1;
        mem_req    = 1'b1;
        wr_index   = miss_index;
        if (mem_ready) begin
          wr_fill    = 1'b1;
          wr_byte_en = 4'hF;
          wr_data    = mem_rdata;
        end
      end
      FLUSH: begin
        rd_index   = scan_index;
        wr_index   = scan_index;
        core_stall = 1'b1;
        if (rd_dirty) begin
          mem_req  = 1'b1;
          mem_we   = 1'b1;
          mem_addr = {rd_tag, scan_index, 2'b00};
          if (mem_ready) wr_clr_dirty = 1'b1;
        end
      end
      default: begin
        core_stall = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      state      <= IDLE;
      scan       <= '0;
      flush_done <= 1'b0;
      miss_index <= '0;
      miss_tag   <= '0;
    end else begin
      if (!flush_req) flush_done <= 1'b0;
      case (state)
        IDLE: begin
          if (flush_start) begin
            state <= FLUSH;
            scan  <= '0;
          end else if (req && !hit) begin
            miss_index <= req_index;
            miss_tag   <= req_tag;
            state      <= (rd_valid && rd_dirty) ? WRITEBACK : FILL;
          end
        end
        WRITEBACK: begin
          if (mem_ready) state <= FILL;
        end
        FILL: begin
          if (mem_ready) state <= IDLE;
        end
        FLUSH: begin
          // Clean lines advance immediately; dirty lines wait for their write.
          if (!rd_dirty || mem_ready) begin
            scan <= scan_next;
            if (scan_next == SCAN_END) begin
              state      <= IDLE;
              flush_done <= flush_req;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/data_cache.md
Name: data_cache

Overview:
- Direct-mapped, write-back, write-allocate data cache between the core's load/store port and main data memory.
- Consumes the core's mem_addr / mem_data_in / mem_write_en stream.
- Stalls the core on misses; runs a req/ready handshake with backing memory.
- On request, flushes all dirty lines so memory is coherent when the core halts.

Parameters:
- XLEN, 32, address/data width.
- INDEX_BITS, 3, line index width; 2**INDEX_BITS one-word (4-byte) lines; tag = XLEN-INDEX_BITS-2 bits.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst_b  in  1  reset, synchronous, active-high.
- core_addr  in  XLEN  byte address; bits [1:0] ignored (word access).
- core_rd_en  in  1  load request.
- core_wr_en  in  1  store request; wins if both asserted.
- core_wdata  in  4x8  store bytes, index 0..3.
- core_rdata  out  4x8  load bytes, valid when core_rd_en & !core_stall.
- core_stall  out  1  core must hold all inputs stable while high.
- mem_addr  out  XLEN  word-aligned memory address.
- mem_wdata  out  4x8  writeback bytes.
- mem_rdata  in  4x8  fill bytes, sampled when mem_ready.
- mem_req  out  1  memory transaction active.
- mem_we  out  1  transaction is a write; qualified by mem_req.
- mem_ready  in  1  one-cycle completion pulse from memory.
- flush_req  in  1  level; start writeback of all dirty lines.
- flush_done  out  1  high in IDLE after a flush completes, until flush_req drops.

Behaviour:
- Reset (rst_b high at an edge):
  - all valid/dirty bits cleared; state IDLE.
  - mem_req=0, mem_we=0, core_stall=0, flush_done=0.
  - Reset mid-transaction abandons it: no partial line update; mem_req drops next cycle.
- Hit (IDLE, valid & tag match):
  - Load: core_rdata combinational from the line, same cycle, core_stall=0.
  - Store: bytes written and dirty set at the edge, core_stall=0.
- Miss (IDLE, request, no hit): core_stall=1 combinationally.
  - Miss index/tag latched at the edge.
  - Victim valid & dirty -> WRITEBACK, else -> FILL.
- WRITEBACK:
  - mem_req=1, mem_we=1, mem_addr={victim_tag, index, 2'b00}, mem_wdata=line data.
  - On mem_ready -> FILL.
- FILL:
  - mem_req=1, mem_we=0, mem_addr={miss_tag, index, 2'b00}.
  - On mem_ready: line <= mem_rdata, tag set, valid=1, dirty=0; -> IDLE.
  - Request replays in IDLE as a hit; stall drops that cycle.
- Latency, with memory ready after N cycles of mem_req:
  - clean miss = N+1 stall cycles.
  - dirty miss = 2N+1 stall cycles.
  - N may be 1 (same-cycle-next ready); mem_ready outside a transaction is ignored.
- FLUSH: entered from IDLE when flush_req=1 and flush_done=0; flush has priority over a simultaneous core request.
  - core_stall=1 throughout.
  - Scan counter 0..2**INDEX_BITS-1.
  - Dirty line: issue writeback as in WRITEBACK, clear dirty on mem_ready, then advance.
  - Clean line: advance in one cycle.
  - After the last index -> IDLE with flush_done=1; valid bits kept.
  - flush_done clears when flush_req deasserts.
- Index wrap: scan counter width INDEX_BITS+1 so the terminal count is unambiguous.
- Core inputs changing while stalled: undefined for the core, but the cache uses only latched miss tag/index, so memory traffic stays consistent.

Decomposition:
- Package mips_cache_pkg:
  - state enum {IDLE, WRITEBACK, FILL, FLUSH}.
  - localparams TAG_BITS and LINES derived from XLEN/INDEX_BITS.
  - byte_word_t (4x8 array) typedef.
- Sub-module cache_line_store:
  - valid/dirty/tag/data arrays; one read port (combinational) and one write port.
  - per-byte write enables, dirty set/clear, synchronous clear on reset.
- data_cache itself holds the FSM, latches, scan counter and muxing.

Test Plan:
- Reset then load 0x0000_0040, memory returns {11,22,33,44} after N=3 -> stall 4 cycles, mem_req/we=1/0 at addr 0x40, core_rdata={11,22,33,44} when stall drops; repeat load -> 0 stall.
- Store {AA,BB,CC,DD} to 0x40 after fill -> no stall, no mem_req; reload returns AA..DD.
- Load 0x0000_0060 (same index as 0x40, 8 lines) with line dirty -> writeback to 0x40 with AA..DD, then fill from 0x60; stall = 2N+1 cycles.
- Store miss to 0x0000_0104 -> fill from 0x104, then merge store; line dirty; no writeback of clean victim.
- Dirty lines at indices 1 and 5, flush_req=1 -> exactly two writes (to those lines' addresses), flush_done=1 after index 7, cleared when flush_req drops.
- Assert rst_b during FILL -> mem_req=0 next cycle, all lines invalid, next load to that address misses.
